// File: rtl/rom_arb_pkg.sv
// Shared types and helpers for the ROM burst arbiter: address/data widths,
// FSM state encoding and the round-robin winner search.
package rom_arb_pkg;

  localparam int AW     = 5;  // ROM address width
  localparam int DW     = 4;  // ROM data width
  localparam int LENW   = 2;  // burst length-minus-one field width
  localparam int MAXREQ = 4;  // largest supported requester count
  localparam int IDXW   = 2;  // requester index width, sized for MAXREQ

  typedef enum logic {
    IDLE,
    BURST
  } state_t;

  typedef struct packed {
    logic            found;
    logic [IDXW-1:0] idx;
  } pick_t;

  // First set request scanning upward from ptr, wrapping modulo nreq.
  function automatic pick_t rr_pick(input logic [MAXREQ-1:0] req,
                                    input logic [IDXW-1:0]   ptr,
                                    input int                nreq);
    pick_t           p;
    logic [IDXW-1:0] cand;
    p = '0;
    for (int i = 0; i < MAXREQ; i++) begin
      if (i < nreq) begin
        cand = IDXW'((int'(ptr) + i) % nreq);
        if (!p.found && req[cand]) begin
          p.found = 1'b1;
          p.idx   = cand;
        end
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/rominfr.sv
// 32x4 ROM with a registered output; the output register only loads when en
// is high, so it holds its last word while the ROM is idle.
module rominfr (
  input  logic       clk,
  input  logic       en,
  input  logic [4:0] addr,
  output logic [3:0] data
);

  localparam logic [3:0] ROM [32] = '{
    4'h2, 4'h2, 4'hE, 4'h2, 4'h4, 4'hA, 4'hC, 4'h0,
    4'hA, 4'h2, 4'hE, 4'h2, 4'h4, 4'hA, 4'hC, 4'h0,
    4'h7, 4'h7, 4'hB, 4'h7, 4'h1, 4'hF, 4'h9, 4'h5,
    4'hF, 4'h7, 4'hB, 4'h7, 4'h1, 4'hF, 4'h9, 4'h5
  };

  // Registered read, one cycle of latency.
  // NOTE: the ROM output register has no reset; its value only matters when
  // the consumer's valid says so, and leaving it unreset keeps it a plain
  // block-RAM style register.
  always_ff @(posedge clk) begin
    if (en) data <= ROM[addr];
  end

endmodule

// File: rtl/rom_burst_arbiter.sv
// Round-robin arbiter and burst sequencer sharing one registered-output ROM
// between NREQ requesters. A granted requester receives 1..4 consecutive
// words, tagged by a one-hot rvalid aligned with the ROM output register.
module rom_burst_arbiter #(
  parameter int NREQ = 2,
  parameter int AW   = 5,
  parameter int DW   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*AW-1:0] addr,
  input  logic [NREQ*2-1:0] len,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   rvalid,
  output logic              rlast,
  output logic [DW-1:0]     rdata,
  output logic              busy
);

  import rom_arb_pkg::*;

  // Burst state
  state_t          state_q, state_d;
  logic [IDXW-1:0] owner_q, owner_d;
  logic [AW-1:0]   cur_addr_q, cur_addr_d;
  logic [LENW-1:0] remain_q, remain_d;
  logic [IDXW-1:0] rr_ptr_q, rr_ptr_d;
  logic [NREQ-1:0] gnt_d;

  // Read-return pipeline stage, aligned with the ROM output register
  logic            p_valid;
  logic [IDXW-1:0] p_owner;
  logic            p_last;

  // Arbitration
  pick_t           win;
  logic [AW-1:0]   sel_addr;
  logic [LENW-1:0] sel_len;
  logic            rom_en;

  assign win    = rr_pick(MAXREQ'(req), rr_ptr_q, NREQ);
  assign rom_en = (state_q == BURST);
  assign busy   = (state_q == BURST);

  // Pick out the winner's base address and length from the flat buses.
  // NOTE: every signal written in an always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    sel_addr = '0;
    sel_len  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win.idx == IDXW'(i)) begin
        sel_addr = addr[i*AW +: AW];
        sel_len  = len[i*LENW +: LENW];
      end
    end
  end

  // Next-state logic: accept a burst in IDLE, walk addresses in BURST.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    cur_addr_d = cur_addr_q;
    remain_d   = remain_q;
    rr_ptr_d   = rr_ptr_q;
    gnt_d      = '0;
    case (state_q)
      IDLE: begin
        if (win.found) begin
          state_d    = BURST;
          owner_d    = win.idx;
          cur_addr_d = sel_addr;
          remain_d   = sel_len;
          for (int i = 0; i < NREQ; i++) gnt_d[i] = (win.idx == IDXW'(i));
        end
      end
      BURST: begin
        cur_addr_d = cur_addr_q + 1'b1;  // wraps 31 -> 0 in AW bits
        remain_d   = remain_q - 1'b1;
        if (remain_q == '0) begin
          state_d  = IDLE;
          rr_ptr_d = (owner_q == IDXW'(NREQ - 1)) ? '0 : owner_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register; gnt is registered so it pulses in the first BURST cycle.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      owner_q    <= '0;
      cur_addr_q <= '0;
      remain_q   <= '0;
      rr_ptr_q   <= '0;
      gnt        <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      cur_addr_q <= cur_addr_d;
      remain_q   <= remain_d;
      rr_ptr_q   <= rr_ptr_d;
      gnt        <= gnt_d;
    end
  end

  // Tag each issued word with its owner and last flag for the return cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      p_valid <= 1'b0;
      p_owner <= '0;
      p_last  <= 1'b0;
    end else begin
      p_valid <= (state_q == BURST);
      p_owner <= owner_q;
      p_last  <= (remain_q == '0);
    end
  end

  // Return strobes; masked by rst so a word in flight when reset asserts is
  // never reported.
  always_comb begin
    rvalid = '0;
    for (int i = 0; i < NREQ; i++) begin
      rvalid[i] = p_valid && !rst && (p_owner == IDXW'(i));
    end
    rlast = p_valid && p_last && !rst;
  end

  rominfr u_rom (
    .clk  (clk),
    .en   (rom_en),
    .addr (cur_addr_q),
    .data (rdata)
  );

endmodule
